// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for serial_adder_ctrl.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder, LSB first, one bit per clock through a single full adder.
// Optional subtract mode (a + ~b + 1) is enabled by macro SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic [1:0]       fa;

  // Two half adders plus an OR; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s1, c1, c2;
    s1 = x ^ y;
    c1 = x & y;
    c2 = s1 & ci;
    return {c1 | c2, s1 ^ ci};
  endfunction

  assign accept   = (state == IDLE) && bus.start;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign fa       = full_add(a_sh[0], b_sh[0], carry);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers carry no reset: they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
      b_sh <= bus.sub ? ~bus.b : bus.b;
`else
      b_sh <= bus.b;
`endif
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
`ifdef SERIAL_ADDER_SUB_EN
      carry <= bus.sub;
`else
      carry <= 1'b0;
`endif
      cnt <= '0;
    end else if (state == SHIFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt == CNT_W'(i)) sum_r[i] <= fa[0];
      end
      carry <= fa[1];
      cnt   <= cnt + 1'b1;
      if (last_bit) cout_r <= fa[1];
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   overlap = 0;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble a/b afterwards, and measure the response.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] s, output logic c,
                       output int lat, output int busy_n);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = ~av;
    bus.b = 8'hC3;
    lat = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
    s = bus.sum;
    c = bus.cout;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.sum !== 8'h00) begin fails++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
    // start asserted while reset is low must not be accepted
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_prio_busy: got %b expected 0", bus.busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    logic [7:0] s; logic c; int lat, bn;
    do_op(8'h00, 8'h00, s, c, lat, bn);
    tests++; if (lat != 8) begin fails++; $display("FAIL zero_latency: got %0d expected 8", lat); end
    tests++; if (bn != 8) begin fails++; $display("FAIL zero_busy_cycles: got %0d expected 8", bn); end
    tests++; if (s !== 8'h00) begin fails++; $display("FAIL zero_sum: got %h expected 00", s); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL zero_cout: got %b expected 0", c); end
    tick();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_add();
    logic [7:0] s; logic c; int lat, bn;
    do_op(8'hFF, 8'h01, s, c, lat, bn);
    tick();
    tests++; if (s !== 8'h00) begin fails++; $display("FAIL ff01_sum: got %h expected 00", s); end
    tests++; if (c !== 1'b1) begin fails++; $display("FAIL ff01_cout: got %b expected 1", c); end
    do_op(8'h5A, 8'h3C, s, c, lat, bn);
    tick();
    tests++; if (s !== 8'h96) begin fails++; $display("FAIL 5a3c_sum: got %h expected 96", s); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL 5a3c_cout: got %b expected 0", c); end
    do_op(8'hA7, 8'hC6, s, c, lat, bn);
    tests++; if ({c, s} !== 9'h16D) begin fails++; $display("FAIL a7c6_result: got %h expected 16d", {c, s}); end
    for (int i = 0; i < 5; i++) tick();
    tests++; if ({bus.cout, bus.sum} !== 9'h16D) begin fails++; $display("FAIL idle_hold: got %h expected 16d", {bus.cout, bus.sum}); end
  endtask

  task automatic test_ignored_start();
    int d0, lat;
    d0 = done_cnt;
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 20) begin tick(); lat++; end
    tests++; if (lat != 8) begin fails++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
    tests++; if (bus.sum !== 8'h46) begin fails++; $display("FAIL ignore_sum: got %h expected 46", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL ignore_cout: got %b expected 0", bus.cout); end
    for (int i = 0; i < 15; i++) tick();
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL ignore_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    d0 = done_cnt;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    tests++; if (bus.sum !== 8'h00) begin fails++; $display("FAIL midrst_sum: got %h expected 00", bus.sum); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL midrst_cout: got %b expected 0", bus.cout); end
    for (int i = 0; i < 15; i++) tick();
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int pulse_at[$];
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.start = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (bus.done === 1'b1) pulse_at.push_back(i);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    tests++; if (pulse_at.size() != 3) begin fails++; $display("FAIL b2b_pulses: got %0d expected 3", pulse_at.size()); end
    if (pulse_at.size() >= 3) begin
      tests++; if (pulse_at[1] - pulse_at[0] != 10) begin fails++; $display("FAIL b2b_period1: got %0d expected 10", pulse_at[1] - pulse_at[0]); end
      tests++; if (pulse_at[2] - pulse_at[1] != 10) begin fails++; $display("FAIL b2b_period2: got %0d expected 10", pulse_at[2] - pulse_at[1]); end
    end
    tests++; if (bus.sum !== 8'h03) begin fails++; $display("FAIL b2b_sum: got %h expected 03", bus.sum); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] s; logic c; int lat, bn;
    bus.sub = 1'b1;
    do_op(8'h10, 8'h01, s, c, lat, bn);
    tick();
    tests++; if (s !== 8'h0F) begin fails++; $display("FAIL sub_1001_sum: got %h expected 0f", s); end
    tests++; if (c !== 1'b1) begin fails++; $display("FAIL sub_1001_cout: got %b expected 1", c); end
    tests++; if (lat != 8) begin fails++; $display("FAIL sub_latency: got %0d expected 8", lat); end
    do_op(8'h01, 8'h02, s, c, lat, bn);
    tick();
    tests++; if (s !== 8'hFF) begin fails++; $display("FAIL sub_0102_sum: got %h expected ff", s); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL sub_0102_cout: got %b expected 0", c); end
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_add();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    tests++; if (overlap != 0) begin fails++; $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
